// File: rtl/dma_req_pkg.sv
// Shared state type, transfer-mode encodings and pin polarity helper
// for the DREQ/DACK requester.
package dma_req_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      XFER,
      RELEASE
   } req_state_t;

   localparam logic MODE_SINGLE = 1'b0;
   localparam logic MODE_DEMAND = 1'b1;

   // Converts a pin level to "asserted" given that pin's polarity.
   function automatic bit pin_act(input bit pin, input bit act_low);
      return pin ^ act_low;
   endfunction

endpackage

// File: rtl/dma_byte_fifo.sv
// Byte-wide synchronous FIFO with same-cycle push and pop. The caller is
// responsible for never pushing when full or popping when empty.
module dma_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                   clk_sys,
   input  logic                   rst,
   input  logic                   push,
   input  logic [7:0]             din,
   input  logic                   pop,
   output logic [7:0]             head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage is not reset; clearing the pointers discards the contents.
   always_ff @(posedge clk_sys) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/dma_dreq_requester.sv
// Peripheral side of the 8237 DREQ/DACK handshake: buffers producer bytes
// and hands one out per I/O-read strobe while DACK is held.
//
// state   | meaning
// IDLE    | no request; waiting for FIFO level to reach THRESH
// REQ     | DREQ asserted, waiting for DACK
// XFER    | DACK held; each IOR_N rising edge pops one byte
// RELEASE | DREQ dropped, waiting for the controller to release DACK
module dma_dreq_requester
   import dma_req_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int THRESH       = 1,
   parameter bit DREQ_ACT_LOW = 1'b0,
   parameter bit DACK_ACT_LOW = 1'b1
) (
   input  logic                   CLK,
   input  logic                   RESET,
   output logic                   DREQ,
   input  logic                   DACK,
   input  logic                   IOR_N,
   input  logic                   EOP_N,
   output logic [7:0]             DB_OUT,
   output logic                   DB_OE,
   input  logic                   mode,
   input  logic [7:0]             wr_data,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   tc_done,
   output logic                   underflow
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] THRESH_L = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0] DEPTH_L  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_L    = CNT_W'(1);

   req_state_t state;
   req_state_t state_nxt;
   logic       ior_q;
   logic       eop_q;
   logic       dreq_q;
   logic       dack_act;
   logic       strobe_end;
   logic       have_data;
   logic       push;
   logic       pop;
   logic [7:0] head;

   assign dack_act   = pin_act(DACK, DACK_ACT_LOW);
   assign strobe_end = dack_act & ~ior_q & IOR_N;
   assign have_data  = (level != '0);
   assign wr_ready   = (level != DEPTH_L);
   assign push       = wr_valid & wr_ready;

   dma_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_sys (CLK),
      .rst     (RESET),
      .push    (push),
      .din     (wr_data),
      .pop     (pop),
      .head    (head),
      .count   (level)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state  <= IDLE;
         ior_q  <= 1'b1;
         eop_q  <= 1'b1;
         dreq_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         ior_q  <= IOR_N;
         eop_q  <= EOP_N;
         dreq_q <= (state_nxt == REQ) || (state_nxt == XFER);
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      tc_done   = 1'b0;
      underflow = 1'b0;
      case (state)
         IDLE: begin
            if (level >= THRESH_L) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (dack_act) begin
               state_nxt = XFER;
            end
         end
         XFER: begin
            if (!dack_act) begin
               // Preempted by the arbiter: keep asking if anything is left.
               state_nxt = have_data ? REQ : IDLE;
            end else begin
               pop = strobe_end & have_data;
               if (strobe_end && !have_data) begin
                  underflow = 1'b1;
                  state_nxt = RELEASE;
               end else if (!eop_q) begin
                  tc_done   = 1'b1;
                  state_nxt = RELEASE;
               end else if (pop) begin
                  if (mode == MODE_DEMAND && level > ONE_L) begin
                     state_nxt = XFER;
                  end else begin
                     state_nxt = RELEASE;
                  end
               end
            end
         end
         RELEASE: begin
            if (!dack_act) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign DREQ   = dreq_q ^ DREQ_ACT_LOW;
   assign DB_OE  = (state == XFER) & dack_act & ~IOR_N;
   assign DB_OUT = DB_OE ? head : 8'hFF;

endmodule

// File: tb/tb_dma_dreq_requester.sv
// Directed bench: four requesters (one per DREQ/DACK polarity pair) share
// one logical stimulus; the default-polarity instance gets the detailed checks.
module tb_dma_dreq_requester;
   import dma_req_pkg::*;

   localparam int MAIN = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       dack;
   logic       ior_n;
   logic       eop_n;
   logic       mode;
   logic       wr_valid;
   logic [7:0] wr_data;

   logic       dack_pin  [4];
   logic       dreq_pin  [4];
   logic [7:0] db_out    [4];
   logic       db_oe     [4];
   logic       wr_ready  [4];
   logic       tc_done   [4];
   logic       underflow [4];
   logic [3:0] level     [4];
   logic [1:0] st        [4];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam bit DRL = (g % 2) == 1;
      localparam bit DKL = (g / 2) == 1;

      assign dack_pin[g] = dack ^ DKL;

      dma_dreq_requester #(
         .DEPTH        (8),
         .THRESH       (1),
         .DREQ_ACT_LOW (DRL),
         .DACK_ACT_LOW (DKL)
      ) u_dut (
         .CLK       (clk),
         .RESET     (rst),
         .DREQ      (dreq_pin[g]),
         .DACK      (dack_pin[g]),
         .IOR_N     (ior_n),
         .EOP_N     (eop_n),
         .DB_OUT    (db_out[g]),
         .DB_OE     (db_oe[g]),
         .mode      (mode),
         .wr_data   (wr_data),
         .wr_valid  (wr_valid),
         .wr_ready  (wr_ready[g]),
         .level     (level[g]),
         .tc_done   (tc_done[g]),
         .underflow (underflow[g])
      );

      assign st[g] = u_dut.state;
   end

   function automatic logic drl(input int g);
      return (g % 2) == 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic [1:0] obs, input req_state_t exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One IOR_N low/high strobe, checking the byte driven while IOR_N is low.
   task automatic strobe(input string tag, input logic [7:0] exp);
      ior_n = 1'b0;
      #1;
      chk8(tag, db_out[MAIN], exp);
      tick();
      ior_n = 1'b1;
      tick();
   endtask

   initial begin
      rst      = 1'b1;
      dack     = 1'b0;
      ior_n    = 1'b1;
      eop_n    = 1'b1;
      mode     = MODE_SINGLE;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      tick();
      tick();

      // Reset values, all polarities
      for (int g = 0; g < 4; g++) begin
         chk1($sformatf("rst_dreq%0d", g), dreq_pin[g], drl(g));
         chk1($sformatf("rst_oe%0d", g), db_oe[g], 1'b0);
         chk8($sformatf("rst_db%0d", g), db_out[g], 8'hFF);
         chk4($sformatf("rst_level%0d", g), level[g], 4'd0);
         chk1($sformatf("rst_tc%0d", g), tc_done[g], 1'b0);
         chk1($sformatf("rst_uf%0d", g), underflow[g], 1'b0);
         chk1($sformatf("rst_wrdy%0d", g), wr_ready[g], 1'b1);
         chk_st($sformatf("rst_state%0d", g), st[g], IDLE);
      end
      rst = 1'b0;

      // Single byte, single mode, all polarities
      wr_valid = 1'b1;
      wr_data  = 8'hA5;
      tick();
      wr_valid = 1'b0;
      #1;
      for (int g = 0; g < 4; g++) begin
         chk4($sformatf("s1_level%0d", g), level[g], 4'd1);
         chk1($sformatf("s1_dreq_pre%0d", g), dreq_pin[g], 1'b0 ^ drl(g));
      end
      tick();
      for (int g = 0; g < 4; g++) begin
         chk1($sformatf("s1_dreq_on%0d", g), dreq_pin[g], 1'b1 ^ drl(g));
      end
      dack  = 1'b1;
      ior_n = 1'b0;
      tick();
      for (int g = 0; g < 4; g++) begin
         chk1($sformatf("s1_oe%0d", g), db_oe[g], 1'b1);
         chk8($sformatf("s1_db%0d", g), db_out[g], 8'hA5);
         chk1($sformatf("s1_dreq_xfer%0d", g), dreq_pin[g], 1'b1 ^ drl(g));
      end
      ior_n = 1'b1;
      tick();
      for (int g = 0; g < 4; g++) begin
         chk4($sformatf("s1_level_post%0d", g), level[g], 4'd0);
         chk1($sformatf("s1_dreq_off%0d", g), dreq_pin[g], 1'b0 ^ drl(g));
         chk_st($sformatf("s1_release%0d", g), st[g], RELEASE);
      end
      dack = 1'b0;
      tick();
      for (int g = 0; g < 4; g++) begin
         chk_st($sformatf("s1_idle%0d", g), st[g], IDLE);
      end

      // Demand mode, four bytes in one DACK
      mode = MODE_DEMAND;
      for (int i = 1; i <= 4; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'(i);
         tick();
      end
      wr_valid = 1'b0;
      #1;
      chk4("s2_level", level[MAIN], 4'd4);
      chk1("s2_dreq", dreq_pin[MAIN], 1'b1);
      dack = 1'b1;
      tick();
      for (int i = 1; i <= 4; i++) begin
         ior_n = 1'b0;
         #1;
         chk8($sformatf("s2_byte%0d", i), db_out[MAIN], 8'(i));
         chk1($sformatf("s2_oe%0d", i), db_oe[MAIN], 1'b1);
         tick();
         ior_n = 1'b1;
         #1;
         chk1($sformatf("s2_tc%0d", i), tc_done[MAIN], 1'b0);
         tick();
         chk1($sformatf("s2_dreq%0d", i), dreq_pin[MAIN], i < 4);
      end
      chk4("s2_level_end", level[MAIN], 4'd0);
      chk_st("s2_release", st[MAIN], RELEASE);
      dack = 1'b0;
      tick();
      chk_st("s2_idle", st[MAIN], IDLE);

      // EOP_N termination on the second strobe
      for (int i = 1; i <= 3; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'(i * 17);
         tick();
      end
      wr_valid = 1'b0;
      dack     = 1'b1;
      tick();
      strobe("s3_byte1", 8'h11);
      ior_n = 1'b0;
      #1;
      chk8("s3_byte2", db_out[MAIN], 8'h22);
      tick();
      eop_n = 1'b0;
      tick();
      ior_n = 1'b1;
      #1;
      chk1("s3_tc_pulse", tc_done[MAIN], 1'b1);
      tick();
      eop_n = 1'b1;
      chk4("s3_level", level[MAIN], 4'd1);
      chk1("s3_dreq_off", dreq_pin[MAIN], 1'b0);
      chk_st("s3_release", st[MAIN], RELEASE);
      #1;
      chk1("s3_tc_once", tc_done[MAIN], 1'b0);
      tick();
      tick();
      chk1("s3_no_rereq", dreq_pin[MAIN], 1'b0);
      chk_st("s3_hold", st[MAIN], RELEASE);
      dack = 1'b0;
      tick();
      chk_st("s3_idle", st[MAIN], IDLE);
      tick();
      chk1("s3_rereq", dreq_pin[MAIN], 1'b1);
      dack = 1'b1;
      tick();
      strobe("s3_byte3", 8'h33);
      chk4("s3_drained", level[MAIN], 4'd0);
      dack = 1'b0;
      tick();

      // Full FIFO, refused push alongside a pop, then ordered drain
      mode = MODE_SINGLE;
      for (int i = 0; i < 8; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'(8'h40 + i);
         tick();
      end
      wr_valid = 1'b0;
      #1;
      chk4("s4_full_level", level[MAIN], 4'd8);
      chk1("s4_full_wrdy", wr_ready[MAIN], 1'b0);
      dack = 1'b1;
      tick();
      ior_n = 1'b0;
      #1;
      chk8("s4_head", db_out[MAIN], 8'h40);
      tick();
      ior_n    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'hEE;
      #1;
      chk1("s4_wrdy_pop", wr_ready[MAIN], 1'b0);
      tick();
      wr_valid = 1'b0;
      chk4("s4_level7", level[MAIN], 4'd7);
      chk_st("s4_release", st[MAIN], RELEASE);
      dack = 1'b0;
      tick();
      mode = MODE_DEMAND;
      tick();
      dack = 1'b1;
      tick();
      for (int i = 1; i < 8; i++) begin
         strobe($sformatf("s4_drain%0d", i), 8'(8'h40 + i));
      end
      chk4("s4_empty", level[MAIN], 4'd0);
      dack = 1'b0;
      tick();

      // Preemption, simultaneous push/pop, spurious DACK in IDLE
      wr_valid = 1'b1;
      wr_data  = 8'hAA;
      tick();
      wr_data  = 8'hBB;
      tick();
      wr_valid = 1'b0;
      dack     = 1'b1;
      tick();
      chk_st("s5_xfer", st[MAIN], XFER);
      dack = 1'b0;
      tick();
      chk_st("s5_preempt", st[MAIN], REQ);
      chk1("s5_dreq", dreq_pin[MAIN], 1'b1);
      chk4("s5_level", level[MAIN], 4'd2);
      dack = 1'b1;
      tick();
      ior_n = 1'b0;
      #1;
      chk8("s5_byte_aa", db_out[MAIN], 8'hAA);
      tick();
      ior_n    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'hCC;
      tick();
      wr_valid = 1'b0;
      chk4("s5_pushpop_level", level[MAIN], 4'd2);
      chk_st("s5_stay", st[MAIN], XFER);
      strobe("s5_byte_bb", 8'hBB);
      strobe("s5_byte_cc", 8'hCC);
      chk_st("s5_release", st[MAIN], RELEASE);
      dack = 1'b0;
      tick();
      dack  = 1'b1;
      ior_n = 1'b0;
      #1;
      chk1("s5_spur_oe", db_oe[MAIN], 1'b0);
      chk8("s5_spur_db", db_out[MAIN], 8'hFF);
      tick();
      ior_n = 1'b1;
      #1;
      chk1("s5_spur_uf", underflow[MAIN], 1'b0);
      tick();
      chk_st("s5_spur_idle", st[MAIN], IDLE);
      chk1("s5_spur_dreq", dreq_pin[MAIN], 1'b0);
      dack = 1'b0;
      tick();

      // Three fill/drain passes with pointers offset from zero
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(r * 16 + i);
            tick();
         end
         wr_valid = 1'b0;
         dack     = 1'b1;
         tick();
         for (int i = 0; i < 8; i++) begin
            strobe($sformatf("s4_wrap%0d_%0d", r, i), 8'(r * 16 + i));
         end
         dack = 1'b0;
         tick();
      end
      chk4("s4_wrap_empty", level[MAIN], 4'd0);

      // Reset in the middle of a transfer
      wr_valid = 1'b1;
      wr_data  = 8'h5A;
      tick();
      wr_valid = 1'b0;
      tick();
      dack = 1'b1;
      tick();
      ior_n = 1'b0;
      #1;
      chk1("rx_oe_before", db_oe[MAIN], 1'b1);
      rst = 1'b1;
      tick();
      chk1("rx_dreq", dreq_pin[MAIN], 1'b0);
      chk1("rx_oe", db_oe[MAIN], 1'b0);
      chk4("rx_level", level[MAIN], 4'd0);
      rst   = 1'b0;
      dack  = 1'b0;
      ior_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
